// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one iteration per clock).
// Optional macro BCD_AUTO_UPDATE_EN: also start a conversion when i_bin changes.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               start_req;
  logic [WORK_W-1:0]  step;

  // Nibble-local correction: any digit >= 5 gets +3, no carry between digits.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_AUTO_UPDATE_EN
  logic [BIN_W-1:0] last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (state_q == IDLE && start_req) begin
      last_q <= i_bin;
    end
  end

  assign start_req = i_start | (i_bin != last_q);
`else
  assign start_req = i_start;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    step    = {add3(work_q[WORK_W-1:BIN_W]), work_q[BIN_W-1:0]} << 1;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = CONV;
          work_d  = {{BCD_W{1'b0}}, i_bin};
          cnt_d   = '0;
        end
      end
      CONV: begin
        work_d = step;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last iteration: publish the digits and return to IDLE.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = IDLE;
          bcd_d   = step[WORK_W-1:BIN_W];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q == CONV);
  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: protocol model pushes expected BCD on accept,
// a negedge monitor pops and compares on every o_done.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 i_start;
  logic [BIN_W-1:0]     i_bin;
  logic                 o_busy;
  logic                 o_done;
  logic [4*DIGITS-1:0]  o_bcd;

  int checks   = 0;
  int failures = 0;

  logic [4*DIGITS-1:0] exp_q[$];
  int                  m_cnt;
  logic                m_done;
  logic [BIN_W-1:0]    m_last;
  int                  m_accepts;
  logic [4*DIGITS-1:0] mon_bcd;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_bcd   (o_bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: idle -> accept on start (or changed value), busy BIN_W cycles, then done.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_last <= '0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
`ifdef BCD_AUTO_UPDATE_EN
        if (i_start || (i_bin != m_last)) begin
`else
        if (i_start) begin
`endif
          exp_q.push_back(to_bcd(int'(i_bin)));
          m_cnt     <= BIN_W;
          m_last    <= i_bin;
          m_accepts <= m_accepts + 1;
        end
      end else begin
        m_cnt  <= m_cnt - 1;
        m_done <= (m_cnt == 1);
      end
    end
  end

  // Monitor
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_bcd = '0;
    end else begin
      chk("busy", 32'(o_busy), 32'(m_cnt != 0));
      chk("done", 32'(o_done), 32'(m_done));
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          mon_bcd = exp_q.pop_front();
          chk("bcd", 32'(o_bcd), 32'(mon_bcd));
        end
      end else begin
        chk("bcd_hold", 32'(o_bcd), 32'(mon_bcd));
      end
    end
  end

  task automatic start_one(input int v);
    @(negedge clk);
    i_bin   = BIN_W'(v);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (BIN_W + 2) @(negedge clk);
  endtask

  task automatic sweep_held(input int lo, input int hi);
    int a0;
    int t;
    i_start = 1'b1;
    for (int k = lo; k <= hi; k++) begin
      i_bin = BIN_W'(k);
      a0 = m_accepts;
      t  = 0;
      while (m_accepts == a0 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (m_accepts == a0) chk("accept_timeout", 32'(k), 32'hFFFF);
    end
    i_start = 1'b0;
    repeat (BIN_W + 3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_accepts = 0;
    reset_n   = 1'b0;
    i_start   = 1'b0;
    i_bin     = '0;
    #12;
    chk("reset_busy", 32'(o_busy), 32'(0));
    chk("reset_done", 32'(o_done), 32'(0));
    chk("reset_bcd",  32'(o_bcd),  32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed values
    start_one(100);
    chk("bcd_100", 32'(o_bcd), 32'h100);
    start_one(255);
    chk("bcd_255", 32'(o_bcd), 32'h255);
    start_one(0);
    chk("bcd_0", 32'(o_bcd), 32'h000);
    start_one(99);
    chk("bcd_99", 32'(o_bcd), 32'h099);

    // Start during conversion is ignored
    @(negedge clk);
    i_bin = 8'd37; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_bin = 8'd200; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (BIN_W) @(negedge clk);
`ifndef BCD_AUTO_UPDATE_EN
    chk("bcd_37", 32'(o_bcd), 32'h037);
`endif
    repeat (BIN_W + 2) @(negedge clk);

    // Held start, new value each accept
    sweep_held(0, 100);
    sweep_held(0, 255);

    // Random values with random idle gaps
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      i_bin   = BIN_W'($urandom_range(0, 255));
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (BIN_W + 3) @(negedge clk);

    // Reset mid-conversion
    @(negedge clk);
    i_bin = 8'd200; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_bcd",  32'(o_bcd),  32'(0));
    i_bin = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (BIN_W + 3) @(negedge clk);
    chk("no_done_after_rst_bcd", 32'(o_bcd), 32'(0));
    start_one(5);
    chk("bcd_5", 32'(o_bcd), 32'h005);

    // Value stepping with i_start low
    @(negedge clk);
    reset_n = 1'b0;
    i_bin   = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      i_bin = (s == 0) ? 8'd0 : (s == 3) ? 8'd2 : 8'd1;
      repeat (BIN_W + 4) @(negedge clk);
    end
`ifdef BCD_AUTO_UPDATE_EN
    chk("auto_bcd", 32'(o_bcd), 32'h002);
`else
    chk("auto_bcd", 32'(o_bcd), 32'h000);
`endif

    repeat (4) @(negedge clk);
    chk("pending", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
